// File: rtl/parking_bcd_scheduler_pkg.sv
// Shared constants for the parking occupancy display path: widths, FSM encoding, blank code.
// The optional BCD_BLANK_EN build uses blank_leading() to suppress leading zero digits.
package parking_bcd_scheduler_pkg;

    localparam int BIN_W      = 8;
    localparam int DIG_W      = 4;
    localparam int NUM_DIGITS = 3;
    localparam int BCD_W      = DIG_W * NUM_DIGITS;

    localparam logic [DIG_W-1:0] BLANK_CODE = 4'hF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

    // Hundreds blanks when zero; tens blanks only when hundreds was blanked too.
    function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        if (bcd[11:8] == 4'd0) begin
            res[11:8] = BLANK_CODE;
            if (bcd[7:4] == 4'd0) begin
                res[7:4] = BLANK_CODE;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/parking_bcd_scheduler_bcd_dabble_step.sv
// One shift-and-add-3 iteration: correct each BCD digit >= 5 by +3, then shift in one binary bit.
module bcd_dabble_step
    import parking_bcd_scheduler_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_in,
    input  logic             bit_in,
    output logic [BCD_W-1:0] bcd_out
);

    logic [BCD_W-1:0] adj;

    always_comb begin
        adj = bcd_in;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (adj[i*DIG_W +: DIG_W] >= 4'd5) begin
                adj[i*DIG_W +: DIG_W] = adj[i*DIG_W +: DIG_W] + 4'd3;
            end
        end
        bcd_out = {adj[BCD_W-2:0], bit_in};
    end

endmodule

// File: rtl/parking_bcd_scheduler.sv
// Parking occupancy counter with one shared double-dabble engine serving occupied and free counts.
// Define BCD_BLANK_EN to write leading zero digits as the blank code 4'hF.
module parking_bcd_scheduler
    import parking_bcd_scheduler_pkg::*;
#(
    parameter int CAPACITY = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             car_in,
    input  logic             car_out,
    output logic [DIG_W-1:0] occ_bcd2,
    output logic [DIG_W-1:0] occ_bcd1,
    output logic [DIG_W-1:0] occ_bcd0,
    output logic [DIG_W-1:0] free_bcd2,
    output logic [DIG_W-1:0] free_bcd1,
    output logic [DIG_W-1:0] free_bcd0,
    output logic             full,
    output logic             empty,
    output logic             busy,
    output logic             upd_occ,
    output logic             upd_free
);

    localparam logic [BIN_W-1:0] CAP_VAL = BIN_W'(CAPACITY);

    logic [BIN_W-1:0] occ_q, occ_d;
    logic             req_occ_q, req_occ_d;
    logic             req_free_q, req_free_d;
    logic [1:0]       state_q, state_d;
    logic             sel_free_q, sel_free_d;
    logic [BIN_W-1:0] shreg_q, shreg_d;
    logic [BCD_W-1:0] acc_q, acc_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [BCD_W-1:0] occ_bcd_q, occ_bcd_d;
    logic [BCD_W-1:0] free_bcd_q, free_bcd_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             upd_occ_q, upd_occ_d;
    logic             upd_free_q, upd_free_d;

    logic [BIN_W-1:0] free_val;
    logic             inc, dec, accepted;
    logic             grant_occ, grant_free;
    logic [BCD_W-1:0] step_out;
    logic [BCD_W-1:0] result;

    bcd_dabble_step u_step (
        .bcd_in  (acc_q),
        .bit_in  (shreg_q[BIN_W-1]),
        .bcd_out (step_out)
    );

    assign free_val   = CAP_VAL - occ_q;
    assign inc        = car_in && !car_out && (occ_q != CAP_VAL);
    assign dec        = car_out && !car_in && (occ_q != '0);
    assign accepted   = inc || dec;
    assign grant_occ  = (state_q == ST_IDLE) && req_occ_q;
    assign grant_free = (state_q == ST_IDLE) && !req_occ_q && req_free_q;

`ifdef BCD_BLANK_EN
    assign result = blank_leading(acc_q);
`else
    assign result = acc_q;
`endif

    always_comb begin
        occ_d = occ_q;
        if (inc) begin
            occ_d = occ_q + 8'd1;
        end else if (dec) begin
            occ_d = occ_q - 8'd1;
        end
        full_d  = (occ_d == CAP_VAL);
        empty_d = (occ_d == '0);
        // A new event in the grant cycle re-arms the flag, so set beats clear.
        req_occ_d  = (req_occ_q && !grant_occ) || accepted;
        req_free_d = (req_free_q && !grant_free) || accepted;
    end

    always_comb begin
        state_d    = state_q;
        sel_free_d = sel_free_q;
        shreg_d    = shreg_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        occ_bcd_d  = occ_bcd_q;
        free_bcd_d = free_bcd_q;
        upd_occ_d  = 1'b0;
        upd_free_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_occ || grant_free) begin
                    sel_free_d = grant_free;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shreg_d = sel_free_q ? free_val : occ_q;
                acc_d   = '0;
                cnt_d   = 3'd7;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                acc_d   = step_out;
                shreg_d = {shreg_q[BIN_W-2:0], 1'b0};
                cnt_d   = cnt_q - 3'd1;
                if (cnt_q == 3'd0) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (sel_free_q) begin
                    free_bcd_d = result;
                    upd_free_d = 1'b1;
                end else begin
                    occ_bcd_d = result;
                    upd_occ_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Both requests start pending so the free count shows CAPACITY after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q      <= '0;
            req_occ_q  <= 1'b1;
            req_free_q <= 1'b1;
            state_q    <= ST_IDLE;
            sel_free_q <= 1'b0;
            shreg_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            occ_bcd_q  <= '0;
            free_bcd_q <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            upd_occ_q  <= 1'b0;
            upd_free_q <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            req_occ_q  <= req_occ_d;
            req_free_q <= req_free_d;
            state_q    <= state_d;
            sel_free_q <= sel_free_d;
            shreg_q    <= shreg_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            occ_bcd_q  <= occ_bcd_d;
            free_bcd_q <= free_bcd_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            upd_occ_q  <= upd_occ_d;
            upd_free_q <= upd_free_d;
        end
    end

    assign {occ_bcd2, occ_bcd1, occ_bcd0}    = occ_bcd_q;
    assign {free_bcd2, free_bcd1, free_bcd0} = free_bcd_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign busy     = (state_q != ST_IDLE);
    assign upd_occ  = upd_occ_q;
    assign upd_free = upd_free_q;

endmodule

// File: tb/tb_parking_bcd_scheduler.sv
// Directed bench for parking_bcd_scheduler: one CAPACITY=200 instance and one CAPACITY=5 instance.
// Expected digits follow BCD_BLANK_EN when the bench is built with that macro.
module tb_parking_bcd_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic car_in = 1'b0, car_out = 1'b0;
    logic car_in5 = 1'b0, car_out5 = 1'b0;

    logic [3:0] occ2, occ1, occ0, free2, free1, free0;
    logic       full, empty, busy, upd_occ, upd_free;
    logic [3:0] occ2_5, occ1_5, occ0_5, free2_5, free1_5, free0_5;
    logic       full5, empty5, busy5, upd_occ5, upd_free5;

    int total = 0;
    int bad = 0;
    int upd_occ_cnt = 0;
    int upd_free_cnt = 0;
    int upd_snap = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (upd_occ) upd_occ_cnt++;
        if (upd_free) upd_free_cnt++;
    end

    parking_bcd_scheduler #(.CAPACITY(200)) dut (
        .clk(clk), .rst(rst), .car_in(car_in), .car_out(car_out),
        .occ_bcd2(occ2), .occ_bcd1(occ1), .occ_bcd0(occ0),
        .free_bcd2(free2), .free_bcd1(free1), .free_bcd0(free0),
        .full(full), .empty(empty), .busy(busy),
        .upd_occ(upd_occ), .upd_free(upd_free)
    );

    parking_bcd_scheduler #(.CAPACITY(5)) dut5 (
        .clk(clk), .rst(rst), .car_in(car_in5), .car_out(car_out5),
        .occ_bcd2(occ2_5), .occ_bcd1(occ1_5), .occ_bcd0(occ0_5),
        .free_bcd2(free2_5), .free_bcd1(free1_5), .free_bcd0(free0_5),
        .full(full5), .empty(empty5), .busy(busy5),
        .upd_occ(upd_occ5), .upd_free(upd_free5)
    );

    function automatic logic [11:0] disp(input logic [11:0] v);
        logic [11:0] r;
        r = v;
`ifdef BCD_BLANK_EN
        if (v[11:8] == 4'd0) begin
            r[11:8] = 4'hF;
            if (v[7:4] == 4'd0) r[7:4] = 4'hF;
        end
`endif
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [11:0] observed, input logic [11:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle pulse on the selected inputs, sampled by exactly one rising edge.
    task automatic applyStimulus(input logic ci, input logic co, input logic ci5, input logic co5);
        @(posedge clk);
        #1;
        car_in = ci; car_out = co; car_in5 = ci5; car_out5 = co5;
        @(posedge clk);
        #1;
        car_in = 1'b0; car_out = 1'b0; car_in5 = 1'b0; car_out5 = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while ((busy || busy5) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("idle_within_budget", {10'd0, busy, busy5}, 12'h000);
    endtask

    initial begin
        $display("[TB] start");
        waitCycles(3);
        checkOutput("rst_occ", {occ2, occ1, occ0}, 12'h000);
        checkOutput("rst_free", {free2, free1, free0}, 12'h000);
        checkOutput("rst_flags", {8'd0, full, empty, busy, upd_occ}, {8'd0, 4'b0100});
        rst = 1'b0;

        waitCycles(30);
        waitIdle(50);
        checkOutput("boot_occ", {occ2, occ1, occ0}, disp(12'h000));
        checkOutput("boot_free", {free2, free1, free0}, disp(12'h200));
        checkOutput("boot_upd_occ_cnt", 12'(upd_occ_cnt), 12'd1);
        checkOutput("boot_upd_free_cnt", 12'(upd_free_cnt), 12'd1);
        checkOutput("boot_free5", {free2_5, free1_5, free0_5}, disp(12'h005));

        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            waitCycles(30);
        end
        checkOutput("occ7", {occ2, occ1, occ0}, disp(12'h007));
        checkOutput("free193", {free2, free1, free0}, disp(12'h193));
        checkOutput("occ7_empty", {11'd0, empty}, 12'h000);

        for (int i = 0; i < 116; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            waitCycles(30);
        end
        checkOutput("occ123", {occ2, occ1, occ0}, disp(12'h123));
        checkOutput("free077", {free2, free1, free0}, disp(12'h077));

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("both_busy_low", {11'd0, busy}, 12'h000);
            waitCycles(1);
        end
        waitCycles(30);
        checkOutput("both_occ_same", {occ2, occ1, occ0}, disp(12'h123));

        upd_snap = upd_occ_cnt;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitCycles(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitCycles(50);
        waitIdle(50);
        checkOutput("rerun_occ125", {occ2, occ1, occ0}, disp(12'h125));
        checkOutput("rerun_free075", {free2, free1, free0}, disp(12'h075));
        checkOutput("rerun_upd_occ", 12'(upd_occ_cnt - upd_snap), 12'd2);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        waitCycles(30);
        checkOutput("cap5_empty_out", {occ2_5, occ1_5, occ0_5}, disp(12'h000));
        checkOutput("cap5_empty_flag", {10'd0, full5, empty5}, 12'h001);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
            waitCycles(30);
        end
        checkOutput("cap5_occ", {occ2_5, occ1_5, occ0_5}, disp(12'h005));
        checkOutput("cap5_free", {free2_5, free1_5, free0_5}, disp(12'h000));
        checkOutput("cap5_full", {10'd0, full5, empty5}, 12'h002);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        waitCycles(30);
        checkOutput("cap5_out_occ", {occ2_5, occ1_5, occ0_5}, disp(12'h004));
        checkOutput("cap5_out_free", {free2_5, free1_5, free0_5}, disp(12'h001));
        checkOutput("cap5_out_full", {10'd0, full5, empty5}, 12'h000);

        upd_snap = upd_occ_cnt + upd_free_cnt;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitCycles(4);
        checkOutput("midshift_busy", {11'd0, busy}, 12'h001);
        rst = 1'b1;
        #1;
        checkOutput("midrst_occ", {occ2, occ1, occ0}, 12'h000);
        checkOutput("midrst_free", {free2, free1, free0}, 12'h000);
        checkOutput("midrst_flags", {8'd0, full, empty, busy, upd_occ}, {8'd0, 4'b0100});
        waitCycles(3);
        checkOutput("midrst_no_upd", 12'(upd_occ_cnt + upd_free_cnt - upd_snap), 12'd0);
        rst = 1'b0;
        waitCycles(30);
        checkOutput("post_rst_occ", {occ2, occ1, occ0}, disp(12'h000));
        checkOutput("post_rst_free", {free2, free1, free0}, disp(12'h200));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
